// File: rtl/rect_draw_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rect_draw_ctrl_if                                                          |
// | Generator strobe/point bus plus SDRAM write req/ack port of the sequencer. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rect_draw_ctrl_if #(
  parameter int COLOR_W = 16
);
  logic [15:0]        rg_x;
  logic [15:0]        rg_y;
  logic               rg_rec_start;
  logic               rg_enable;
  logic               rg_seed;
  logic               rg_renew;
  logic               rg_new_frame;
  logic [15:0]        rg_o_x;
  logic [15:0]        rg_o_y;
  logic               rg_all_done;
  logic               wr_req;
  logic [15:0]        wr_x;
  logic [15:0]        wr_y;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_ack;

  modport master (
    output rg_x, rg_y, rg_rec_start, rg_enable, rg_seed, rg_renew, rg_new_frame,
    output wr_req, wr_x, wr_y, wr_data,
    input  rg_o_x, rg_o_y, rg_all_done, wr_ack
  );

  modport slave (
    input  rg_x, rg_y, rg_rec_start, rg_enable, rg_seed, rg_renew, rg_new_frame,
    input  wr_req, wr_x, wr_y, wr_data,
    output rg_o_x, rg_o_y, rg_all_done, wr_ack
  );
endinterface
`default_nettype wire

// File: rtl/rect_draw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rect_draw_ctrl                                                             |
// | Rectangle draw sequencer: two-point capture, generator strobing, pixel     |
// | forwarding over req/ack. Optional screen clipping via RECT_CLIP_EN.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rect_draw_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int MAX_PIX    = 65535,
`ifdef RECT_CLIP_EN
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
`endif
  parameter int COLOR_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pt_valid,
  input  logic [15:0]        pt_x,
  input  logic [15:0]        pt_y,
  input  logic [COLOR_W-1:0] color,
  input  logic               frame_start,
  rect_draw_ctrl_if.master   bus,
  output logic               busy,
  output logic               draw_done,
  output logic               draw_err,
  output logic [15:0]        pix_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_P2 = 3'd1,
    S_SEED    = 3'd2,
    S_SETTLE  = 3'd3,
    S_WRITE   = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ABORT   = 3'd7
  } state_t;

  localparam logic [7:0]  c_SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] c_MAX_PIX     = 16'(MAX_PIX);

  state_t             r_state, w_state_nx;
  logic [15:0]        r_rg_x, r_rg_y, w_rg_x_nx, w_rg_y_nx;
  logic               r_rec_start, r_enable, r_seed, r_renew, r_new_frame;
  logic               w_rec_start_nx, w_enable_nx, w_seed_nx, w_renew_nx, w_new_frame_nx;
  logic               r_wr_req, w_wr_req_nx;
  logic [15:0]        r_wr_x, r_wr_y, w_wr_x_nx, w_wr_y_nx;
  logic [COLOR_W-1:0] r_color, w_color_nx;
  logic [7:0]         r_settle, w_settle_nx;
  logic [15:0]        r_pix_cnt, w_pix_cnt_nx;
  logic               r_busy, w_busy_nx;
  logic               r_done, w_done_nx;
  logic               r_err, w_err_nx;
  logic               w_clip;
  logic               w_budget_hit;

`ifdef RECT_CLIP_EN
  // Budget counts generated pixels, clipped or not, so a runaway generator still aborts.
  logic [15:0] r_step, w_step_nx;
  assign w_clip       = ({16'd0, bus.rg_o_x} >= 32'(H_RES)) || ({16'd0, bus.rg_o_y} >= 32'(V_RES));
  assign w_budget_hit = (r_step == c_MAX_PIX);
`else
  assign w_clip       = 1'b0;
  assign w_budget_hit = (r_pix_cnt == c_MAX_PIX);
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_rg_x_nx      = r_rg_x;
    w_rg_y_nx      = r_rg_y;
    w_rec_start_nx = 1'b0;
    w_enable_nx    = 1'b0;
    w_seed_nx      = 1'b0;
    w_renew_nx     = 1'b0;
    w_new_frame_nx = 1'b0;
    w_wr_req_nx    = r_wr_req;
    w_wr_x_nx      = r_wr_x;
    w_wr_y_nx      = r_wr_y;
    w_color_nx     = r_color;
    w_settle_nx    = r_settle;
    w_pix_cnt_nx   = r_pix_cnt;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    w_err_nx       = r_err;
`ifdef RECT_CLIP_EN
    w_step_nx      = r_step;
`endif
    case (r_state)
      S_IDLE, S_DONE, S_ABORT: begin
        w_new_frame_nx = frame_start;
        if (pt_valid) begin
          w_state_nx     = S_WAIT_P2;
          w_rec_start_nx = 1'b1;
          w_rg_x_nx      = pt_x;
          w_rg_y_nx      = pt_y;
          w_color_nx     = color;
          w_pix_cnt_nx   = '0;
          w_err_nx       = 1'b0;
          w_busy_nx      = 1'b1;
`ifdef RECT_CLIP_EN
          w_step_nx      = '0;
`endif
        end
      end
      S_WAIT_P2: begin
        if (pt_valid) begin
          w_state_nx  = S_SEED;
          w_enable_nx = 1'b1;
          w_rg_x_nx   = pt_x;
          w_rg_y_nx   = pt_y;
        end
      end
      S_SEED: begin
        w_state_nx  = S_SETTLE;
        w_seed_nx   = 1'b1;
        w_settle_nx = '0;
      end
      S_SETTLE: begin
        if (r_settle == c_SETTLE_LAST) begin
`ifdef RECT_CLIP_EN
          if (r_step != c_MAX_PIX) w_step_nx = r_step + 16'd1;
`endif
          if (w_clip) begin
            w_state_nx = S_CHECK;
          end else begin
            w_state_nx  = S_WRITE;
            w_wr_req_nx = 1'b1;
            w_wr_x_nx   = bus.rg_o_x;
            w_wr_y_nx   = bus.rg_o_y;
          end
        end else begin
          w_settle_nx = r_settle + 8'd1;
        end
      end
      S_WRITE: begin
        if (bus.wr_ack) begin
          w_state_nx  = S_CHECK;
          w_wr_req_nx = 1'b0;
          if (r_pix_cnt != c_MAX_PIX) w_pix_cnt_nx = r_pix_cnt + 16'd1;
        end
      end
      S_CHECK: begin
        if (bus.rg_all_done) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end else if (w_budget_hit) begin
          w_state_nx = S_ABORT;
          w_err_nx   = 1'b1;
          w_busy_nx  = 1'b0;
        end else begin
          w_state_nx  = S_SETTLE;
          w_renew_nx  = 1'b1;
          w_settle_nx = '0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rg_x      <= '0;
      r_rg_y      <= '0;
      r_rec_start <= 1'b0;
      r_enable    <= 1'b0;
      r_seed      <= 1'b0;
      r_renew     <= 1'b0;
      r_new_frame <= 1'b0;
      r_wr_req    <= 1'b0;
      r_wr_x      <= '0;
      r_wr_y      <= '0;
      r_color     <= '0;
      r_settle    <= '0;
      r_pix_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef RECT_CLIP_EN
      r_step      <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_rg_x      <= w_rg_x_nx;
      r_rg_y      <= w_rg_y_nx;
      r_rec_start <= w_rec_start_nx;
      r_enable    <= w_enable_nx;
      r_seed      <= w_seed_nx;
      r_renew     <= w_renew_nx;
      r_new_frame <= w_new_frame_nx;
      r_wr_req    <= w_wr_req_nx;
      r_wr_x      <= w_wr_x_nx;
      r_wr_y      <= w_wr_y_nx;
      r_color     <= w_color_nx;
      r_settle    <= w_settle_nx;
      r_pix_cnt   <= w_pix_cnt_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
`ifdef RECT_CLIP_EN
      r_step      <= w_step_nx;
`endif
    end
  end

  assign bus.rg_x         = r_rg_x;
  assign bus.rg_y         = r_rg_y;
  assign bus.rg_rec_start = r_rec_start;
  assign bus.rg_enable    = r_enable;
  assign bus.rg_seed      = r_seed;
  assign bus.rg_renew     = r_renew;
  assign bus.rg_new_frame = r_new_frame;
  assign bus.wr_req       = r_wr_req;
  assign bus.wr_x         = r_wr_x;
  assign bus.wr_y         = r_wr_y;
  assign bus.wr_data      = r_color;
  assign busy             = r_busy;
  assign draw_done        = r_done;
  assign draw_err         = r_err;
  assign pix_cnt          = r_pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rect_draw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rect_draw_ctrl                                                          |
// | Scoreboard bench: stand-in generator, write-port model, in-order monitor.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rect_draw_ctrl;
  localparam int COLOR_W = 16;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pt_valid = 1'b0, pt_valid2 = 1'b0;
  logic [15:0] pt_x = '0, pt_y = '0, color = '0;
  logic        frame_start = 1'b0;
  logic        busy, draw_done, draw_err, busy2, draw_done2, draw_err2;
  logic [15:0] pix_cnt, pix_cnt2;

  int   n_checks = 0, n_fail = 0;
  int   n_wr = 0, n_wr2 = 0, ack_delay = 0;
  int   first_x = 0, first_y = 0, last_x = 0, last_y = 0;
  bit   mark_first = 1'b0;
  pix_t exp_q[$], exp_q2[$];

  rect_draw_ctrl_if #(.COLOR_W(COLOR_W)) bus ();
  rect_draw_ctrl_if #(.COLOR_W(COLOR_W)) bus2 ();

  rect_draw_ctrl #(.SETTLE_CYC(2), .MAX_PIX(65535), .COLOR_W(COLOR_W)) dut (
    .clk(clk), .rst_n(rst_n), .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .color(color),
    .frame_start(frame_start), .bus(bus), .busy(busy), .draw_done(draw_done),
    .draw_err(draw_err), .pix_cnt(pix_cnt)
  );

  // Second instance with a tiny budget, fed by a generator that never advances.
  rect_draw_ctrl #(.SETTLE_CYC(2), .MAX_PIX(16), .COLOR_W(COLOR_W)) dut_budget (
    .clk(clk), .rst_n(rst_n), .pt_valid(pt_valid2), .pt_x(pt_x), .pt_y(pt_y), .color(color),
    .frame_start(frame_start), .bus(bus2), .busy(busy2), .draw_done(draw_done2),
    .draw_err(draw_err2), .pix_cnt(pix_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Stand-in generator order: full rows over the box plus one overscan row, then a tail
  // pixel two rows below the box at the right edge.
  function automatic void stub_pix(input int idx, input int xl, input int xh, input int yl,
                                   input int yh, output int px, output int py);
    int w;
    w = xh - xl + 1;
    if (idx < w * (yh - yl + 2)) begin
      px = xl + idx % w;
      py = yl + idx / w;
    end else begin
      px = xh;
      py = yh + 2;
    end
  endfunction

  task automatic push_rect(input int ax, input int ay, input int bx, input int by,
                           input logic [15:0] col, output int n);
    int xl, xh, yl, yh, total, px, py;
    pix_t e;
    xl = (ax < bx) ? ax : bx;  xh = (ax < bx) ? bx : ax;
    yl = (ay < by) ? ay : by;  yh = (ay < by) ? by : ay;
    total = (xh - xl + 1) * (yh - yl + 2) + 1;
    n = 0;
    for (int i = 0; i < total; i++) begin
      stub_pix(i, xl, xh, yl, yh, px, py);
`ifdef RECT_CLIP_EN
      if (px >= 800 || py >= 600) continue;
`endif
      e.x = 16'(px); e.y = 16'(py); e.d = col;
      exp_q.push_back(e);
      n++;
    end
  endtask

  // Generator model for the main instance.
  initial begin
    int p1x, p1y, p2x, p2y, xl, xh, yl, yh, idx, total, px, py;
    bit act;
    act = 1'b0; idx = 0; total = 1;
    p1x = 0; p1y = 0; p2x = 0; p2y = 0; xl = 0; xh = 0; yl = 0; yh = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0; idx = 0;
        bus.rg_o_x = '0; bus.rg_o_y = '0; bus.rg_all_done = 1'b0;
      end else begin
        if (bus.rg_rec_start) begin p1x = int'(bus.rg_x); p1y = int'(bus.rg_y); end
        if (bus.rg_enable)    begin p2x = int'(bus.rg_x); p2y = int'(bus.rg_y); end
        if (bus.rg_seed) begin
          xl = (p1x < p2x) ? p1x : p2x;  xh = (p1x < p2x) ? p2x : p1x;
          yl = (p1y < p2y) ? p1y : p2y;  yh = (p1y < p2y) ? p2y : p1y;
          total = (xh - xl + 1) * (yh - yl + 2) + 1;
          idx = 0; act = 1'b1;
        end else if (bus.rg_renew && act && idx < total - 1) begin
          idx++;
        end
        if (act) begin
          stub_pix(idx, xl, xh, yl, yh, px, py);
          bus.rg_o_x = 16'(px); bus.rg_o_y = 16'(py);
          bus.rg_all_done = (idx == total - 1);
        end
      end
    end
  end

  // Write-port model: ack tied high when ack_delay==0, else ack ack_delay cycles after req.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (ack_delay == 0) begin
        bus.wr_ack = 1'b1; cnt = 0;
      end else if (!bus.wr_req) begin
        bus.wr_ack = 1'b0; cnt = 0;
      end else begin
        bus.wr_ack = (cnt == ack_delay); cnt++;
      end
    end
  end

  // Monitor: every cycle with a pending request must show the scoreboard head.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.wr_req) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr_unexpected: got write (%0d,%0d), expected none", bus.wr_x, bus.wr_y);
        end else begin
          e = exp_q[0];
          chk("wr_x", int'(bus.wr_x), int'(e.x));
          chk("wr_y", int'(bus.wr_y), int'(e.y));
          chk("wr_data", int'(bus.wr_data), int'(e.d));
          if (bus.wr_ack) void'(exp_q.pop_front());
        end
        if (bus.wr_ack) begin
          if (mark_first) begin
            first_x = int'(bus.wr_x); first_y = int'(bus.wr_y); mark_first = 1'b0;
          end
          last_x = int'(bus.wr_x); last_y = int'(bus.wr_y);
          n_wr++;
        end
      end
    end
  end

  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus2.wr_req && bus2.wr_ack) begin
        if (exp_q2.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr2_unexpected: got write (%0d,%0d), expected none", bus2.wr_x, bus2.wr_y);
        end else begin
          e = exp_q2.pop_front();
          chk("wr2_x", int'(bus2.wr_x), int'(e.x));
          chk("wr2_y", int'(bus2.wr_y), int'(e.y));
          chk("wr2_data", int'(bus2.wr_data), int'(e.d));
        end
        n_wr2++;
      end
    end
  end

  task automatic send_pt(input bit second, input int x, input int y);
    @(negedge clk);
    if (second) pt_valid2 = 1'b1; else pt_valid = 1'b1;
    pt_x = 16'(x); pt_y = 16'(y);
    @(negedge clk);
    pt_valid = 1'b0; pt_valid2 = 1'b0;
  endtask

  task automatic run_draw(input bit second, input int budget, output int pulses);
    int k;
    pulses = 0;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (second ? draw_done2 : draw_done) pulses++;
      if (!(second ? busy2 : busy)) break;
    end
    if (k == budget) begin
      n_checks++; n_fail++;
      $display("FAIL draw_timeout: busy still high after %0d cycles, expected low", budget);
    end
    repeat (4) begin
      @(negedge clk);
      if (second ? draw_done2 : draw_done) pulses++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_draw_done"}, int'(draw_done), 0);
    chk({tag, "_draw_err"}, int'(draw_err), 0);
    chk({tag, "_pix_cnt"}, int'(pix_cnt), 0);
    chk({tag, "_wr_req"}, int'(bus.wr_req), 0);
    chk({tag, "_wr_x"}, int'(bus.wr_x), 0);
    chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
    chk({tag, "_rg_x"}, int'(bus.rg_x), 0);
    chk({tag, "_strobes"}, int'({bus.rg_rec_start, bus.rg_enable, bus.rg_seed, bus.rg_renew}), 0);
  endtask

  task automatic full_draw(input string tag, input int ax, input int ay, input int bx,
                           input int by, input logic [15:0] col, input int exp_n);
    int n, p, w0;
    push_rect(ax, ay, bx, by, col, n);
    color = col; w0 = n_wr; mark_first = 1'b1;
    send_pt(1'b0, ax, ay);
    send_pt(1'b0, bx, by);
    run_draw(1'b0, 6000, p);
    chk({tag, "_done_pulses"}, p, 1);
    chk({tag, "_writes"}, n_wr - w0, exp_n);
    chk({tag, "_pix_cnt"}, int'(pix_cnt), exp_n);
    chk({tag, "_draw_err"}, int'(draw_err), 0);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int n, p, k, w0, clip_n;
    bus.rg_o_x = '0; bus.rg_o_y = '0; bus.rg_all_done = 1'b0; bus.wr_ack = 1'b1;
    bus2.rg_o_x = 16'd50; bus2.rg_o_y = 16'd60; bus2.rg_all_done = 1'b0; bus2.wr_ack = 1'b1;

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    chk("new_frame_idle", int'(bus.rg_new_frame), 1);

    // Test 1: first strobe cycle carries the point, then the full draw.
    push_rect(100, 100, 110, 105, 16'h1234, n);
    color = 16'h1234; w0 = n_wr; mark_first = 1'b1;
    send_pt(1'b0, 100, 100);
    chk("t1_rec_start", int'(bus.rg_rec_start), 1);
    chk("t1_rg_x", int'(bus.rg_x), 100);
    chk("t1_busy", int'(busy), 1);
    send_pt(1'b0, 110, 105);
    chk("t1_enable", int'(bus.rg_enable), 1);
    chk("t1_rg_xy", int'({bus.rg_x, bus.rg_y}), int'({16'd110, 16'd105}));
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    chk("new_frame_busy", int'(bus.rg_new_frame), 0);
    run_draw(1'b0, 6000, p);
    chk("t1_done_pulses", p, 1);
    chk("t1_writes", n_wr - w0, 78);
    chk("t1_first", first_x * 65536 + first_y, 100 * 65536 + 100);
    chk("t1_last", last_x * 65536 + last_y, 110 * 65536 + 107);
    chk("t1_pix_cnt", int'(pix_cnt), 78);
    chk("t1_queue_left", exp_q.size(), 0);

    // Test 2: reversed corners, started from DONE together with a frame strobe.
    push_rect(110, 105, 100, 100, 16'h00F0, n);
    color = 16'h00F0; w0 = n_wr;
    @(negedge clk);
    pt_valid = 1'b1; pt_x = 16'd110; pt_y = 16'd105; frame_start = 1'b1;
    @(negedge clk);
    pt_valid = 1'b0; frame_start = 1'b0;
    chk("t2_rec_start", int'(bus.rg_rec_start), 1);
    chk("t2_new_frame", int'(bus.rg_new_frame), 1);
    send_pt(1'b0, 100, 100);
    run_draw(1'b0, 6000, p);
    chk("t2_done_pulses", p, 1);
    chk("t2_writes", n_wr - w0, 78);
    chk("t2_pix_cnt", int'(pix_cnt), 78);
    chk("t2_draw_err", int'(draw_err), 0);
    chk("t2_queue_left", exp_q.size(), 0);

    // Test 3: slow write port; the monitor checks the held pixel every waiting cycle.
    ack_delay = 5;
    full_draw("t3", 100, 100, 110, 105, 16'h0BEE, 78);
    ack_delay = 0;
    @(negedge clk);

    // Test 4: frozen generator against a 16-pixel budget.
    color = 16'h0F0F;
    for (int i = 0; i < 16; i++) exp_q2.push_back({16'd50, 16'd60, 16'h0F0F});
    send_pt(1'b1, 20, 20);
    send_pt(1'b1, 30, 30);
    run_draw(1'b1, 3000, p);
    chk("t4_done_pulses", p, 0);
    chk("t4_draw_err", int'(draw_err2), 1);
    chk("t4_pix_cnt", int'(pix_cnt2), 16);
    chk("t4_writes", n_wr2, 16);
    chk("t4_queue_left", exp_q2.size(), 0);

    // Test 5: asynchronous reset right after the 30th write is accepted.
    push_rect(100, 100, 110, 105, 16'h5A5A, n);
    color = 16'h5A5A; w0 = n_wr;
    send_pt(1'b0, 100, 100);
    send_pt(1'b0, 110, 105);
    for (k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (n_wr - w0 >= 30) break;
    end
    if (k == 3000) begin
      n_checks++; n_fail++;
      $display("FAIL t5_reach30: got %0d writes, expected 30", n_wr - w0);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t5_reset");
    chk("t5_writes_before_reset", n_wr - w0, 30);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_draw("t5_redraw", 100, 100, 110, 105, 16'hC3C3, 78);

    // Test 6: box straddling the screen edge.
`ifdef RECT_CLIP_EN
    clip_n = 50;
`else
    clip_n = 111;
`endif
    full_draw("t6", 795, 590, 805, 598, 16'h0C0C, clip_n);
    chk("t6_first", first_x * 65536 + first_y, 795 * 65536 + 590);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
